// File: rtl/rv32_decode_if.sv
// Fetch-to-decode, writeback and decode-to-execute bundle for rv32_decode.
// master: pipeline/hazard side driving inputs; slave: the decode stage.
interface rv32_decode_if;
    logic        stall_in;
    logic        flush_in;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        wb_write_in;
    logic [4:0]  wb_rd_in;
    logic [31:0] wb_value_in;

    logic        valid_out;
    logic [31:0] pc_out;
    logic [4:0]  rs1_out;
    logic [4:0]  rs2_out;
    logic [4:0]  rd_out;
    logic [31:0] rs1_value_out;
    logic [31:0] rs2_value_out;
    logic [31:0] imm_value_out;
    logic [2:0]  funct3_out;
    logic [3:0]  alu_op_out;
    logic        alu_src1_out;
    logic        alu_src2_out;
    logic [1:0]  branch_op_out;
    logic        mem_read_out;
    logic        mem_write_out;
    logic        rd_write_out;
    logic        illegal_out;

    modport master (
        output stall_in, flush_in, pc_in, instr_in,
        output wb_write_in, wb_rd_in, wb_value_in,
        input  valid_out, pc_out, rs1_out, rs2_out, rd_out,
        input  rs1_value_out, rs2_value_out, imm_value_out,
        input  funct3_out, alu_op_out, alu_src1_out, alu_src2_out,
        input  branch_op_out, mem_read_out, mem_write_out,
        input  rd_write_out, illegal_out
    );

    modport slave (
        input  stall_in, flush_in, pc_in, instr_in,
        input  wb_write_in, wb_rd_in, wb_value_in,
        output valid_out, pc_out, rs1_out, rs2_out, rd_out,
        output rs1_value_out, rs2_value_out, imm_value_out,
        output funct3_out, alu_op_out, alu_src1_out, alu_src2_out,
        output branch_op_out, mem_read_out, mem_write_out,
        output rd_write_out, illegal_out
    );
endinterface

// File: rtl/rv32_decode.sv
// RV32I decode stage: field/immediate decode, 32x32 register file with
// write-through bypass, registered outputs. Ports: clk, reset, bus (slave).
module rv32_decode (
    input  logic         clk,
    input  logic         reset,
    rv32_decode_if.slave bus
);
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    localparam logic [1:0] BR_NONE = 2'd0;
    localparam logic [1:0] BR_JAL  = 2'd1;
    localparam logic [1:0] BR_JALR = 2'd2;
    localparam logic [1:0] BR_COND = 2'd3;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rs1_value;
        logic [31:0] rs2_value;
        logic [31:0] imm;
        logic [2:0]  funct3;
        logic [3:0]  alu_op;
        logic        alu_src1;
        logic        alu_src2;
        logic [1:0]  branch_op;
        logic        mem_read;
        logic        mem_write;
        logic        rd_write;
        logic        illegal;
    } dec_t;

    function automatic logic [3:0] alu_for(
        input logic [2:0] f3,
        input logic       alt
    );
        logic [3:0] op;
        case (f3)
            3'd0:    op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;

    assign instr  = bus.instr_in;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign rd     = instr[11:7];

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};

    logic is_op;
    logic is_opimm;
    logic is_lui;
    logic is_auipc;
    logic is_jal;
    logic is_jalr;
    logic is_branch;
    logic is_load;
    logic is_store;

    assign is_op     = (opcode == 7'b0110011);
    assign is_opimm  = (opcode == 7'b0010011);
    assign is_lui    = (opcode == 7'b0110111);
    assign is_auipc  = (opcode == 7'b0010111);
    assign is_jal    = (opcode == 7'b1101111);
    assign is_jalr   = (opcode == 7'b1100111);
    assign is_branch = (opcode == 7'b1100011);
    assign is_load   = (opcode == 7'b0000011);
    assign is_store  = (opcode == 7'b0100011);

    // Register file; x0 is never written and reads as zero.
    logic [31:0] regs [32];
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic        wb_hit;

    assign wb_hit = bus.wb_write_in && (bus.wb_rd_in != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_hit) begin
            regs[bus.wb_rd_in] <= bus.wb_value_in;
        end
    end

    // Same-cycle writeback is forwarded so decode never reads stale data.
    always_comb begin
        rs1_value = '0;
        rs2_value = '0;
        if (rs1 != 5'd0) begin
            rs1_value = (wb_hit && bus.wb_rd_in == rs1)
                      ? bus.wb_value_in : regs[rs1];
        end
        if (rs2 != 5'd0) begin
            rs2_value = (wb_hit && bus.wb_rd_in == rs2)
                      ? bus.wb_value_in : regs[rs2];
        end
    end

    dec_t dec;
    dec_t nxt;
    logic illegal;

    always_comb begin
        dec           = '0;
        illegal       = 1'b0;
        dec.valid     = 1'b1;
        dec.pc        = bus.pc_in;
        dec.rs1       = rs1;
        dec.rs2       = rs2;
        dec.rd        = rd;
        dec.rs1_value = rs1_value;
        dec.rs2_value = rs2_value;
        dec.funct3    = funct3;
        dec.alu_op    = ALU_ADD;
        dec.branch_op = BR_NONE;

        unique case (1'b1)
            is_op: begin
                dec.rd_write = 1'b1;
                if (funct7 == 7'h00) begin
                    dec.alu_op = alu_for(funct3, 1'b0);
                end else if (funct7 == 7'h20 &&
                             (funct3 == 3'd0 || funct3 == 3'd5)) begin
                    dec.alu_op = alu_for(funct3, 1'b1);
                end else begin
                    illegal = 1'b1;
                end
            end
            is_opimm: begin
                dec.imm      = imm_i;
                dec.alu_src2 = 1'b1;
                dec.rd_write = 1'b1;
                if (funct3 == 3'd1) begin
                    dec.alu_op = ALU_SLL;
                    illegal    = (funct7 != 7'h00);
                end else if (funct3 == 3'd5) begin
                    dec.alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                    illegal    = (funct7 != 7'h00) && (funct7 != 7'h20);
                end else begin
                    dec.alu_op = alu_for(funct3, 1'b0);
                end
            end
            is_lui: begin
                dec.imm      = imm_u;
                dec.alu_op   = ALU_PASS;
                dec.alu_src2 = 1'b1;
                dec.rd_write = 1'b1;
            end
            is_auipc: begin
                dec.imm      = imm_u;
                dec.alu_src1 = 1'b1;
                dec.alu_src2 = 1'b1;
                dec.rd_write = 1'b1;
            end
            is_jal: begin
                dec.imm       = imm_j;
                dec.branch_op = BR_JAL;
                dec.rd_write  = 1'b1;
            end
            is_jalr: begin
                dec.imm       = imm_i;
                dec.branch_op = BR_JALR;
                dec.rd_write  = 1'b1;
            end
            is_branch: begin
                dec.imm       = imm_b;
                dec.branch_op = BR_COND;
                illegal       = (funct3 == 3'd2) || (funct3 == 3'd3);
            end
            is_load: begin
                dec.imm      = imm_i;
                dec.mem_read = 1'b1;
                dec.alu_src2 = 1'b1;
                dec.rd_write = 1'b1;
                illegal      = (funct3 == 3'd3) || (funct3 >= 3'd6);
            end
            is_store: begin
                dec.imm       = imm_s;
                dec.mem_write = 1'b1;
                dec.alu_src2  = 1'b1;
                illegal       = (funct3 >= 3'd3);
            end
            default: illegal = 1'b1;
        endcase

        if (rd == 5'd0) begin
            dec.rd_write = 1'b0;
        end
    end

    // Illegal encodings travel as a flagged bubble so execute can trap
    // with the right PC while no side effect is enabled.
    always_comb begin
        nxt = dec;
        if (illegal) begin
            nxt         = '0;
            nxt.valid   = 1'b1;
            nxt.illegal = 1'b1;
            nxt.pc      = dec.pc;
            nxt.rs1     = dec.rs1;
            nxt.rs2     = dec.rs2;
            nxt.rd      = dec.rd;
            nxt.funct3  = dec.funct3;
        end
    end

    dec_t q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (bus.stall_in) begin
            q <= q;
        end else if (bus.flush_in) begin
            q <= '0;
        end else begin
            q <= nxt;
        end
    end

    assign bus.valid_out     = q.valid;
    assign bus.pc_out        = q.pc;
    assign bus.rs1_out       = q.rs1;
    assign bus.rs2_out       = q.rs2;
    assign bus.rd_out        = q.rd;
    assign bus.rs1_value_out = q.rs1_value;
    assign bus.rs2_value_out = q.rs2_value;
    assign bus.imm_value_out = q.imm;
    assign bus.funct3_out    = q.funct3;
    assign bus.alu_op_out    = q.alu_op;
    assign bus.alu_src1_out  = q.alu_src1;
    assign bus.alu_src2_out  = q.alu_src2;
    assign bus.branch_op_out = q.branch_op;
    assign bus.mem_read_out  = q.mem_read;
    assign bus.mem_write_out = q.mem_write;
    assign bus.rd_write_out  = q.rd_write;
    assign bus.illegal_out   = q.illegal;
endmodule

// File: tb/tb_rv32_decode.sv
// Self-checking bench for rv32_decode: hand-derived expected outputs are
// queued with each stimulus cycle and compared after the clock edge.
module tb_rv32_decode;
    logic clk;
    logic reset;

    rv32_decode_if dif ();

    rv32_decode dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic        s1;
        logic        s2;
        logic [1:0]  br;
        logic        mr;
        logic        mw;
        logic        rdw;
        logic        ill;
    } exp_t;

    exp_t sb [$];
    int   n_chk;
    int   n_ok;
    int   cyc;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got === exp) begin
            n_ok++;
        end else begin
            $display("FAIL c%0d %s: got %h expected %h", cyc, tag, got, exp);
        end
    endtask

    function automatic exp_t mk(
        input logic v, input logic [31:0] pc, input logic [4:0] rd,
        input logic [31:0] r1, input logic [31:0] r2,
        input logic [31:0] imm, input logic [2:0] f3,
        input logic [3:0] alu, input logic s1, input logic s2,
        input logic [1:0] br, input logic mr, input logic mw,
        input logic rdw, input logic ill
    );
        exp_t e;
        e.v = v; e.pc = pc; e.rd = rd; e.r1 = r1; e.r2 = r2;
        e.imm = imm; e.f3 = f3; e.alu = alu; e.s1 = s1; e.s2 = s2;
        e.br = br; e.mr = mr; e.mw = mw; e.rdw = rdw; e.ill = ill;
        return e;
    endfunction

    task automatic step(
        input logic rst, input logic stl, input logic fl,
        input logic [31:0] pc, input logic [31:0] instr,
        input logic ww, input logic [4:0] wrd, input logic [31:0] wv,
        input exp_t e
    );
        exp_t x;
        reset           = rst;
        dif.stall_in    = stl;
        dif.flush_in    = fl;
        dif.pc_in       = pc;
        dif.instr_in    = instr;
        dif.wb_write_in = ww;
        dif.wb_rd_in    = wrd;
        dif.wb_value_in = wv;
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        x = sb.pop_front();
        check("valid", 32'(dif.valid_out), 32'(x.v));
        check("pc", dif.pc_out, x.pc);
        check("rd", 32'(dif.rd_out), 32'(x.rd));
        check("rs1_value", dif.rs1_value_out, x.r1);
        check("rs2_value", dif.rs2_value_out, x.r2);
        check("imm", dif.imm_value_out, x.imm);
        check("funct3", 32'(dif.funct3_out), 32'(x.f3));
        check("alu_op", 32'(dif.alu_op_out), 32'(x.alu));
        check("src1", 32'(dif.alu_src1_out), 32'(x.s1));
        check("src2", 32'(dif.alu_src2_out), 32'(x.s2));
        check("branch_op", 32'(dif.branch_op_out), 32'(x.br));
        check("mem_read", 32'(dif.mem_read_out), 32'(x.mr));
        check("mem_write", 32'(dif.mem_write_out), 32'(x.mw));
        check("rd_write", 32'(dif.rd_write_out), 32'(x.rdw));
        check("illegal", 32'(dif.illegal_out), 32'(x.ill));
    endtask

    exp_t bub;
    exp_t jal;

    initial begin
        n_chk = 0;
        n_ok  = 0;
        cyc   = 0;
        bub   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        jal   = mk(1, 32'h11C, 5, 0, 0, 16, 0, 0, 0, 0, 1, 0, 0, 1, 0);

        // reset with a pending write to x5 that must be discarded
        step(1, 0, 0, 32'h40, 32'h00500093, 1, 5, 32'hAAAA, bub);
        step(1, 0, 0, 32'h44, 32'h00500093, 1, 5, 32'hAAAA, bub);
        // ADDI x1,x0,5 ; rs2 field is x5, must read 0
        step(0, 0, 0, 32'h100, 32'h00500093, 0, 0, 0,
             mk(1, 32'h100, 1, 0, 0, 5, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        // ADD x2,x1,x1 with same-cycle writeback x1
        step(0, 0, 0, 32'h104, 32'h00108133, 1, 1, 32'hDEADBEEF,
             mk(1, 32'h104, 2, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0,
                0, 0, 0, 0, 0, 1, 0));
        // x1 now from the array; write to x0 discarded
        step(0, 0, 0, 32'h108, 32'h00108133, 1, 0, 32'h1234,
             mk(1, 32'h108, 2, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0,
                0, 0, 0, 0, 0, 1, 0));
        // ADD x2,x0,x0 reads x0 after the attempted write
        step(0, 0, 0, 32'h10C, 32'h00000133, 0, 0, 0,
             mk(1, 32'h10C, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        // SW x2,-4(x1)
        step(0, 0, 0, 32'h110, 32'hFE20AE23, 0, 0, 0,
             mk(1, 32'h110, 28, 32'hDEADBEEF, 0, 32'hFFFFFFFC, 2, 0,
                0, 1, 0, 0, 1, 0, 0));
        // LUI x3,0x12345
        step(0, 0, 0, 32'h114, 32'h123451B7, 0, 0, 0,
             mk(1, 32'h114, 3, 0, 0, 32'h12345000, 5, 10,
                0, 1, 0, 0, 0, 1, 0));
        // BEQ x1,x2,+8
        step(0, 0, 0, 32'h118, 32'h00208463, 0, 0, 0,
             mk(1, 32'h118, 8, 32'hDEADBEEF, 0, 8, 0, 0,
                0, 0, 3, 0, 0, 0, 0));
        // JAL x5,+16
        step(0, 0, 0, 32'h11C, 32'h010002EF, 0, 0, 0, jal);
        // stall 3 cycles with changing instr; regfile write to x7 still lands
        step(0, 1, 0, 32'h120, 32'h00500093, 1, 7, 32'h77, jal);
        step(0, 1, 0, 32'h124, 32'h00108133, 0, 0, 0, jal);
        step(0, 1, 0, 32'h128, 32'hFE20AE23, 0, 0, 0, jal);
        // stall beats flush
        step(0, 1, 1, 32'h12C, 32'h00500093, 0, 0, 0, jal);
        // flush alone
        step(0, 0, 1, 32'h130, 32'h00500093, 0, 0, 0, bub);
        // all-zero word is illegal
        step(0, 0, 0, 32'h200, 32'h00000000, 0, 0, 0,
             mk(1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        // OP with funct7 = 0x01
        step(0, 0, 0, 32'h204, 32'h02108133, 0, 0, 0,
             mk(1, 32'h204, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        // ADDI x9,x7,1 : x7 written during stall
        step(0, 0, 0, 32'h208, 32'h00138493, 0, 0, 0,
             mk(1, 32'h208, 9, 32'h77, 32'hDEADBEEF, 1, 0, 0,
                0, 1, 0, 0, 0, 1, 0));
        // SRAI x4,x1,3
        step(0, 0, 0, 32'h20C, 32'h4030D213, 0, 0, 0,
             mk(1, 32'h20C, 4, 32'hDEADBEEF, 0, 32'h403, 5, 7,
                0, 1, 0, 0, 0, 1, 0));
        // SUB x5,x1,x2
        step(0, 0, 0, 32'h210, 32'h402082B3, 0, 0, 0,
             mk(1, 32'h210, 5, 32'hDEADBEEF, 0, 0, 0, 1,
                0, 0, 0, 0, 0, 1, 0));
        // ADDI x0,x0,1 : rd_write forced off
        step(0, 0, 0, 32'h214, 32'h00100013, 0, 0, 0,
             mk(1, 32'h214, 0, 0, 32'hDEADBEEF, 1, 0, 0,
                0, 1, 0, 0, 0, 0, 0));
        // load funct3 011 is illegal
        step(0, 0, 0, 32'h218, 32'h00013083, 0, 0, 0,
             mk(1, 32'h218, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1));
        // LW x6,8(x1)
        step(0, 0, 0, 32'h21C, 32'h0080A303, 0, 0, 0,
             mk(1, 32'h21C, 6, 32'hDEADBEEF, 0, 8, 2, 0,
                0, 1, 0, 1, 0, 1, 0));
        // reset mid-stream overrides stall and writeback
        step(1, 1, 0, 32'h220, 32'h00108133, 1, 1, 32'h5555, bub);
        // ADD x2,x1,x1 : registers cleared by reset
        step(0, 0, 0, 32'h300, 32'h00108133, 0, 0, 0,
             mk(1, 32'h300, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        // AUIPC x1,0x1
        step(0, 0, 0, 32'h304, 32'h00001097, 0, 0, 0,
             mk(1, 32'h304, 1, 0, 0, 32'h1000, 1, 0,
                1, 1, 0, 0, 0, 1, 0));

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end
endmodule

// File: doc/rv32_decode.md
# rv32_decode

Second stage of the RV32I five-stage pipeline: consumes the PC/instruction pair latched by fetch, decodes it, reads the 32×32 integer register file, generates the immediate, and registers everything for execute. It also owns the register file write port driven by writeback. It honours the hazard unit's stall/flush controls with the same rules as fetch, so the hazard unit drives both stages identically.

## Interface
Parameters: none (XLEN fixed at 32, 32 architectural registers).

- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- stall_in  in  1  hazard: hold all output registers
- flush_in  in  1  hazard: replace this cycle's result with a bubble
- pc_in  in  32  PC from fetch
- instr_in  in  32  instruction from fetch
- wb_write_in  in  1  writeback register write enable
- wb_rd_in  in  5  writeback destination index
- wb_value_in  in  32  writeback data
- valid_out  out  1  1 = real instruction, 0 = bubble
- pc_out  out  32  PC of the decoded instruction
- rs1_out, rs2_out  out  5 each  source indices, for hazard/forwarding
- rd_out  out  5  destination index
- rs1_value_out, rs2_value_out  out  32 each  register file read data
- imm_value_out  out  32  sign-extended immediate
- funct3_out  out  3  raw funct3, for branch condition and load/store width
- alu_op_out  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_SRC2
- alu_src1_out  out  1  0 = rs1, 1 = pc
- alu_src2_out  out  1  0 = rs2, 1 = imm
- branch_op_out  out  2  0 none, 1 JAL, 2 JALR, 3 conditional branch
- mem_read_out, mem_write_out  out  1 each  load / store
- rd_write_out  out  1  register writeback enable
- illegal_out  out  1  unrecognised opcode/funct

## Operation
- Field extraction: rs1 = instr[19:15], rs2 = instr[24:20], rd = instr[11:7].
- Immediates are I/S/B/U/J per RV32I, bit 31 sign-extended. B and J immediates have bit 0 = 0. R-type: imm = 0.
- Decode:
  - OP: alu_op from funct3/funct7[5]; SUB/SRA need funct7 = 0x20. Any other funct7 value is illegal.
  - OP-IMM: src2 = imm. SRAI is funct7[5] = 1. Slli/srli/srai with other funct7 bits set are illegal.
  - LUI: PASS_SRC2 with src2 = imm.
  - AUIPC: ADD, src1 = pc, src2 = imm.
  - JAL/JALR: rd_write = 1. Execute forms the link value; the decoded fields carry no ALU selection for it.
  - BRANCH: branch_op = 3. funct3 010/011 is illegal.
  - LOAD: mem_read, ADD, src2 = imm. funct3 011/110/111 is illegal.
  - STORE: mem_write, src2 = imm, rd_write = 0. funct3 ≥ 011 is illegal.
- rd_write_out is forced to 0 when rd = 0.
- Illegal encoding: outputs a bubble with illegal_out = 1 and valid_out = 1, carrying pc_out and instr fields.
- Bubble definition: valid_out = 0. All control outputs (mem_read, mem_write, rd_write, branch_op, illegal) = 0. rd_out = 0. Data outputs are don't-care, but the RTL drives them to 0.
- Register file:
  - x0 always reads 0. Writes to x0 are discarded.
  - Written at the clock edge when wb_write_in = 1, independent of stall/flush.
  - Write-through bypass: if wb_write_in = 1 and wb_rd_in ≠ 0 equals rs1/rs2 in the same cycle, the read value is wb_value_in.

## Timing
- Latency 1 cycle: instr_in sampled at edge N appears decoded after edge N.
- reset = 1 at an edge:
  - All outputs take the bubble value, with pc_out = 0.
  - All 32 registers are cleared to 0.
  - reset overrides stall, flush and any writeback in that cycle.
- stall_in = 1: every output register holds. Stall beats flush when both are asserted. Register file writes still occur. Held rs values are NOT refreshed; execute's forwarding covers that.
- flush_in = 1, stall_in = 0: outputs load a bubble.
- Reset deasserted mid-stream: first decoded instruction appears one edge after the first non-reset edge.

## Test plan
- Reset: assert reset 2 cycles with wb_write_in = 1, wb_rd_in = 5 → valid_out = 0, pc_out = 0, all control 0. A subsequent read of x5 returns 0.
- ADDI x1,x0,5 (0x00500093), pc 0x100 → next cycle:
  - pc_out = 0x100, rd_out = 1, imm = 5.
  - alu_op = ADD, alu_src2 = 1, rd_write = 1, valid = 1.
- Bypass: ADD x2,x1,x1 (0x00108133) while wb writes x1 = 0xDEADBEEF same cycle → rs1/rs2_value_out = 0xDEADBEEF. Writing x0 = 0x1234 then reading x0 → 0.
- SW x2,-4(x1) (0xFE20AE23) → imm = 0xFFFFFFFC, mem_write = 1, rd_write = 0, alu_src2 = 1.
- Stall 3 cycles while instr_in changes → outputs unchanged. Stall+flush together → held. Flush alone → bubble next edge.
- instr_in = 0x00000000 → illegal_out = 1, valid_out = 1, mem/rd_write = 0. ADD with funct7 = 0x01 → illegal_out = 1.
